// File: rtl/ahb_spi_flash_xip.sv
// ahb_spi_flash_xip: AHB-lite read-only slave that maps a SPI NOR flash into
// the bus address space. Each legal read stalls its data phase while a
// READ (0x03) frame is run on the PMOD pins in SPI mode 0, MSB first.
// Optional feature macro FLASH_XIP_BUFFER_EN: adds a one-word read buffer
// that serves repeat reads of the last fetched word with zero wait states.
module ahb_spi_flash_xip #(
    parameter int ADDR_W  = 24,
    parameter int CLK_DIV = 2,
    parameter int CS_IDLE = 2
) (
    input  logic        HCLK,
    input  logic        HRST,
    input  logic        HSELx,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [1:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    input  logic        i_pad_pmodb_miso,
    output logic        o_pad_pmodb_mosi,
    output logic        o_pad_pmodb_cs,
    output logic        o_pad_pmodb_spi_clk
);

    localparam int WA_W  = ADDR_W - 2;
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_DONE, ST_GAP
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;   // SPI half-period / gap timer
    logic [5:0]       bit_cnt_q, bit_cnt_d;   // bit index within current field
    logic [31:0]      tx_sr_q, tx_sr_d;       // command + address, MSB first
    logic [31:0]      rx_sr_q, rx_sr_d;       // data bytes, first byte ends in [31:24]
    logic [WA_W-1:0]  addr_q, addr_d;         // word address of the current fetch
    logic             pend_q, pend_d;         // miss waiting for the gap to expire
    logic             err_q, err_d;           // first cycle of an ERROR response
    logic             cs_q, cs_d;
    logic             spi_clk_q, spi_clk_d;
    logic             hready_q, hready_d;
    logic [1:0]       hresp_q, hresp_d;
    logic [31:0]      hrdata_q, hrdata_d;

    logic [WA_W-1:0]  haddr_word, start_word;
    logic [5:0]       field_last_idx;
    logic [31:0]      rx_word, hit_data;
    logic             accept, legal, acc_err, acc_rd, hit, acc_hit, acc_miss;
    logic             shifting, tick, rise, fall, bit_done, gap_done;
    logic             start_now, fetch_done;
    logic             unused_inputs;

    // Write data, HTRANS[0] and the address bits above the flash window carry no meaning here.
    assign unused_inputs = ^{HWDATA, HADDR[31:ADDR_W], HTRANS[0]};

    // Bus request decode.
    assign haddr_word = HADDR[ADDR_W-1:2];
    assign accept     = HSELx & HTRANS[1] & hready_q;
    assign legal      = !HWRITE &&
                        ((HSIZE == 2'b00) ||
                         (HSIZE == 2'b01 && !HADDR[0]) ||
                         (HSIZE == 2'b10 && HADDR[1:0] == 2'b00));
    assign acc_err    = accept & !legal;
    assign acc_rd     = accept & legal;
    assign acc_hit    = acc_rd & hit;
    assign acc_miss   = acc_rd & !hit;

`ifdef FLASH_XIP_BUFFER_EN
    logic             buf_valid_q, buf_valid_d;
    logic [WA_W-1:0]  buf_tag_q, buf_tag_d;
    logic [31:0]      buf_data_q, buf_data_d;

    assign hit      = buf_valid_q && (buf_tag_q == haddr_word);
    assign hit_data = buf_data_q;
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // SPI timing events: spi_clk toggles every CLK_DIV cycles while a frame runs.
    assign shifting       = state_q inside {ST_CMD, ST_ADDR, ST_DATA};
    assign tick           = shifting && (div_cnt_q == DIV_LAST);
    assign rise           = tick & !spi_clk_q;
    assign fall           = tick &  spi_clk_q;
    assign field_last_idx = (state_q == ST_CMD)  ? 6'd7  :
                            (state_q == ST_ADDR) ? 6'd23 : 6'd31;
    assign bit_done       = fall && (bit_cnt_q == field_last_idx);
    assign fetch_done     = (state_q == ST_DATA) && bit_done;
    assign gap_done       = (state_q == ST_GAP) && (div_cnt_q == GAP_LAST);
    assign start_now      = ((state_q == ST_IDLE) && acc_miss) ||
                            (gap_done && (pend_q || acc_miss));
    assign start_word     = pend_q ? addr_q : haddr_word;
    assign rx_word        = {rx_sr_q[7:0], rx_sr_q[15:8], rx_sr_q[23:16], rx_sr_q[31:24]};

    // FSM state register.
    always_ff @(posedge HCLK) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (HRST) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (acc_miss) state_d = ST_CMD;
            ST_CMD:  if (bit_done) state_d = ST_ADDR;
            ST_ADDR: if (bit_done) state_d = ST_DATA;
            ST_DATA: if (bit_done) state_d = ST_DONE;
            ST_DONE: state_d = ST_GAP;
            ST_GAP:  if (gap_done) state_d = start_now ? ST_CMD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: SPI shifting, bus handshake and response datapath.
    always_comb begin
        div_cnt_d = '0;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        addr_d    = addr_q;
        pend_d    = pend_q;
        err_d     = 1'b0;
        cs_d      = cs_q;
        spi_clk_d = spi_clk_q;
        hready_d  = hready_q;
        hresp_d   = 2'b00;
        hrdata_d  = hrdata_q;

        if (start_now) begin
            cs_d      = 1'b0;
            spi_clk_d = 1'b0;
            bit_cnt_d = '0;
            pend_d    = 1'b0;
            tx_sr_d   = {8'h03, 24'({start_word, 2'b00})};
        end else if (shifting) begin
            if (tick) spi_clk_d = ~spi_clk_q;
            else      div_cnt_d = div_cnt_q + 1'b1;
            if (rise && state_q == ST_DATA)
                rx_sr_d = {rx_sr_q[30:0], i_pad_pmodb_miso};
            if (fall) begin
                tx_sr_d   = {tx_sr_q[30:0], 1'b0};
                bit_cnt_d = bit_done ? 6'd0 : bit_cnt_q + 1'b1;
            end
            if (fetch_done) begin
                cs_d     = 1'b1;
                hready_d = 1'b1;
                hrdata_d = rx_word;
            end
        end else if (state_q == ST_GAP && !gap_done) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        // A data phase never overlaps a running frame, so these cannot collide with fetch_done.
        if (acc_err) begin
            hready_d = 1'b0;
            hresp_d  = 2'b01;
            err_d    = 1'b1;
        end else if (err_q) begin
            hready_d = 1'b1;
            hresp_d  = 2'b01;
        end else if (acc_miss) begin
            hready_d = 1'b0;
            addr_d   = haddr_word;
            if (!start_now) pend_d = 1'b1;
        end else if (acc_hit) begin
            hrdata_d = hit_data;
        end
    end

    // Datapath and pad registers.
    always_ff @(posedge HCLK) begin
        if (HRST) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            addr_q    <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            cs_q      <= 1'b1;
            spi_clk_q <= 1'b0;
            hready_q  <= 1'b1;
            hresp_q   <= 2'b00;
            hrdata_q  <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            addr_q    <= addr_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            cs_q      <= cs_d;
            spi_clk_q <= spi_clk_d;
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
            hrdata_q  <= hrdata_d;
        end
    end

`ifdef FLASH_XIP_BUFFER_EN
    // Refill the buffer on every completed fetch.
    always_comb begin
        buf_valid_d = buf_valid_q | fetch_done;
        buf_tag_d   = fetch_done ? addr_q  : buf_tag_q;
        buf_data_d  = fetch_done ? rx_word : buf_data_q;
    end

    // Buffer valid bit; cleared by reset.
    always_ff @(posedge HCLK) begin
        if (HRST) buf_valid_q <= 1'b0;
        else      buf_valid_q <= buf_valid_d;
    end

    // Buffer tag and data storage.
    always_ff @(posedge HCLK) begin
        // NOTE: storage guarded by a valid bit needs no reset; only the valid bit is reset.
        buf_tag_q  <= buf_tag_d;
        buf_data_q <= buf_data_d;
    end
`endif

    assign HRDATA              = hrdata_q;
    assign HREADY              = hready_q;
    assign HRESP               = hresp_q;
    assign o_pad_pmodb_mosi    = tx_sr_q[31];
    assign o_pad_pmodb_cs      = cs_q;
    assign o_pad_pmodb_spi_clk = spi_clk_q;

endmodule

// File: tb/tb_ahb_spi_flash_xip.sv
// tb_ahb_spi_flash_xip: directed bench for ahb_spi_flash_xip with a small
// SPI NOR flash model answering READ (0x03) frames in mode 0.
`timescale 1ns/1ps
module tb_ahb_spi_flash_xip;

    localparam int ADDR_W      = 24;
    localparam int CLK_DIV     = 2;
    localparam int CS_IDLE     = 2;
    localparam int FRAME_WAITS = 128 * CLK_DIV;
    localparam int LIMIT       = 2000;

    logic        HCLK = 1'b0;
    logic        HRST;
    logic        HSELx;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [1:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic        miso;
    logic        mosi;
    logic        cs;
    logic        spi_clk;

    int n_total = 0;
    int n_bad   = 0;

    ahb_spi_flash_xip #(
        .ADDR_W (ADDR_W),
        .CLK_DIV(CLK_DIV),
        .CS_IDLE(CS_IDLE)
    ) dut (
        .HCLK               (HCLK),
        .HRST               (HRST),
        .HSELx              (HSELx),
        .HADDR              (HADDR),
        .HTRANS             (HTRANS),
        .HWRITE             (HWRITE),
        .HSIZE              (HSIZE),
        .HWDATA             (HWDATA),
        .HRDATA             (HRDATA),
        .HREADY             (HREADY),
        .HRESP              (HRESP),
        .i_pad_pmodb_miso   (miso),
        .o_pad_pmodb_mosi   (mosi),
        .o_pad_pmodb_cs     (cs),
        .o_pad_pmodb_spi_clk(spi_clk)
    );

    always #5 HCLK = ~HCLK;

    // Flash model state.
    logic [7:0]  mem [0:1023];
    logic [31:0] rx_sh;
    logic [7:0]  cap_cmd;
    logic [23:0] cap_addr;
    int          rx_cnt;
    int          tx_cnt;
    int          cs_falls;

    initial begin
        miso     = 1'b0;
        rx_sh    = '0;
        cap_cmd  = '0;
        cap_addr = '0;
        rx_cnt   = 0;
        tx_cnt   = 0;
        cs_falls = 0;
    end

    // Count frame starts.
    always @(negedge cs) cs_falls++;

    // Command/address capture on rising spi_clk; cs high aborts the frame.
    always @(posedge spi_clk or posedge cs) begin
        if (cs !== 1'b0) begin
            rx_cnt = 0;
        end else if (rx_cnt < 32) begin
            rx_sh = {rx_sh[30:0], mosi};
            rx_cnt++;
            if (rx_cnt == 32) begin
                cap_cmd  = rx_sh[31:24];
                cap_addr = rx_sh[23:0];
            end
        end
    end

    // Data bits are driven on falling spi_clk once the address is complete.
    always @(negedge spi_clk or posedge cs) begin
        logic [7:0] b;
        if (cs !== 1'b0) begin
            tx_cnt = 0;
        end else if (rx_cnt == 32 && tx_cnt < 32) begin
            b    = mem[10'(cap_addr + 24'(tx_cnt / 8))];
            miso = b[3'(7 - (tx_cnt % 8))];
            tx_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one address phase at the current falling edge; return in the first data-phase cycle.
    task automatic addr_phase(input logic [31:0] a, input logic [1:0] sz, input logic wr);
        HSELx  = 1'b1;
        HTRANS = 2'b10;
        HADDR  = a;
        HSIZE  = sz;
        HWRITE = wr;
        @(negedge HCLK);
        HSELx  = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    // Count wait states until HREADY, bounded.
    task automatic wait_ready(output int waits);
        waits = 0;
        while (HREADY !== 1'b1 && waits < LIMIT) begin
            waits++;
            @(negedge HCLK);
        end
        if (waits >= LIMIT) check("hready_timeout", 32'(HREADY), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] sz,
                           output int waits, output logic [31:0] data, output logic [1:0] resp);
        addr_phase(a, sz, 1'b0);
        wait_ready(waits);
        data = HRDATA;
        resp = HRESP;
    endtask

    // Two-cycle ERROR response check.
    task automatic expect_error(input string tag);
        check({tag, "_c1_hready"}, 32'(HREADY), 32'd0);
        check({tag, "_c1_hresp"},  32'(HRESP),  32'd1);
        @(negedge HCLK);
        check({tag, "_c2_hready"}, 32'(HREADY), 32'd1);
        check({tag, "_c2_hresp"},  32'(HRESP),  32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          w;
        int          n;
        int          falls0;
        logic [31:0] d;
        logic [1:0]  r;

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 5 + (i >> 6));
        mem[10'h104] = 8'h11;
        mem[10'h105] = 8'h22;
        mem[10'h106] = 8'h33;
        mem[10'h107] = 8'h44;

        HRST   = 1'b1;
        HSELx  = 1'b0;
        HADDR  = '0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 2'b10;
        HWDATA = 32'hDEAD_BEEF;

        // Reset values.
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_hready",  32'(HREADY),  32'd1);
        check("rst_hresp",   32'(HRESP),   32'd0);
        check("rst_hrdata",  HRDATA,       32'd0);
        check("rst_cs",      32'(cs),      32'd1);
        check("rst_spi_clk", 32'(spi_clk), 32'd0);
        check("rst_mosi",    32'(mosi),    32'd0);
        HRST = 1'b0;
        repeat (5) @(negedge HCLK);
        check("idle_cs",       32'(cs),  32'd1);
        check("idle_no_frame", cs_falls, 32'd0);

        // Word read from idle.
        addr_phase(32'h0000_0104, 2'b10, 1'b0);
        check("rd104_cs_low",   32'(cs),     32'd0);
        check("rd104_hready0",  32'(HREADY), 32'd0);
        check("rd104_mosi_b7",  32'(mosi),   32'd0);
        wait_ready(w);
        check("rd104_waits",  w,             FRAME_WAITS);
        check("rd104_data",   HRDATA,        32'h4433_2211);
        check("rd104_resp",   32'(HRESP),    32'd0);
        check("rd104_cs_done",32'(cs),       32'd1);
        check("rd104_cmd",    32'(cap_cmd),  32'h03);
        check("rd104_addr",   32'(cap_addr), 32'h00_0104);

        // Illegal accesses: write, then misaligned half.
        falls0 = cs_falls;
        addr_phase(32'h0, 2'b10, 1'b1);
        expect_error("wr0");
        addr_phase(32'h3, 2'b01, 1'b0);
        expect_error("half3");
        check("err_no_frame", cs_falls, 32'(falls0));

        // Byte read at 0x3 fetches aligned word 0.
        do_read(32'h3, 2'b00, w, d, r);
        check("byte3_waits", w,             FRAME_WAITS);
        check("byte3_data",  d,             32'h744F_2A05);
        check("byte3_resp",  32'(r),        32'd0);
        check("byte3_addr",  32'(cap_addr), 32'h00_0000);

        // Same-word reads back to back.
        repeat (4) @(negedge HCLK);
        do_read(32'h100, 2'b10, w, d, r);
        check("rd100_waits", w, FRAME_WAITS);
        check("rd100_data",  d, 32'h7853_2E09);
        falls0 = cs_falls;
        do_read(32'h102, 2'b00, w, d, r);
`ifdef FLASH_XIP_BUFFER_EN
        check("rd102_hit_waits", w,        32'd0);
        check("rd102_hit_data",  d,        32'h7853_2E09);
        check("rd102_no_frame",  cs_falls, 32'(falls0));
`else
        check("rd102_b2b_waits", w,             32'(CS_IDLE + FRAME_WAITS));
        check("rd102_data",      d,             32'h7853_2E09);
        check("rd102_frame",     cs_falls,      32'(falls0 + 1));
        check("rd102_addr",      32'(cap_addr), 32'h00_0100);
`endif
        check("rd102_resp", 32'(r), 32'd0);

        // Reset in the middle of the data field.
        repeat (4) @(negedge HCLK);
        addr_phase(32'h180, 2'b10, 1'b0);
        n = 0;
        while (tx_cnt < 10 && n < LIMIT) begin
            n++;
            @(negedge HCLK);
        end
        check("abort_reach_bit10", 32'(tx_cnt >= 10), 32'd1);
        HRST = 1'b1;
        @(posedge HCLK);
        #1;
        check("abort_cs",      32'(cs),      32'd1);
        check("abort_spi_clk", 32'(spi_clk), 32'd0);
        check("abort_hready",  32'(HREADY),  32'd1);
        @(negedge HCLK);
        HRST = 1'b0;
        @(negedge HCLK);

        do_read(32'h200, 2'b10, w, d, r);
        check("rd200_waits", w,             FRAME_WAITS);
        check("rd200_data",  d,             32'h7C57_320D);
        check("rd200_resp",  32'(r),        32'd0);
        check("rd200_addr",  32'(cap_addr), 32'h00_0200);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
